// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS run-control sequencer: default widths,
// halt opcode default and the run-state encoding.
package mips_ctrl_pkg;

  localparam int unsigned PC_W_DEF        = 8;
  localparam int unsigned INSTR_W_DEF     = 8;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned DEBOUNCE_DEF    = 4;
  localparam logic [7:0]  HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } run_state_e;

endpackage

// File: rtl/mips_run_ctrl_btn_debounce.sv
// Conditions one raw push-button: 2-flop synchronizer, debounce counter that
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples, and
// a single-cycle pulse on each rising edge of the accepted level.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   btn        - raw button, asynchronous to clk
//   pulse      - registered 1-cycle pulse per accepted press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_prev;

  // Synchronize, count differing samples, flip level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      sync       <= {sync[0], btn};
      level_prev <= level;
      pulse      <= level & ~level_prev;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run-control sequencer for the MIPS core: produces the core clock-enable for
// free-run, single-step and halt, with PC breakpoint and halt-opcode stops.
// Ports:
//   Clk_O, Reset           - clock, async active-low reset
//   Btn_Step, Btn_Run      - raw push-buttons
//   Bkpt_En, Bkpt_PC       - breakpoint enable and address
//   PC, Instruction        - observed core PC and fetched instruction
//   CPU_En                 - combinational core clock-enable
//   Halted, Brk_Hit,
//   Halt_Op, Step_Count    - registered status and saturating executed count
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned          PC_W            = PC_W_DEF,
  parameter int unsigned          INSTR_W         = INSTR_W_DEF,
  parameter int unsigned          CNT_W           = CNT_W_DEF,
  parameter int unsigned          DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE     = INSTR_W'(HALT_OPCODE_DEF)
) (
  input  logic               Clk_O,
  input  logic               Reset,
  input  logic               Btn_Step,
  input  logic               Btn_Run,
  input  logic               Bkpt_En,
  input  logic [PC_W-1:0]    Bkpt_PC,
  input  logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] Instruction,
  output logic               CPU_En,
  output logic               Halted,
  output logic               Brk_Hit,
  output logic               Halt_Op,
  output logic [CNT_W-1:0]   Step_Count
);

  run_state_e state;
  run_state_e next_state;
  logic       step_p;
  logic       run_p;
  logic       skip;
  logic       is_halt_op;
  logic       is_bkpt;
  logic       en;
  logic       set_skip;
  logic       clr_flags;
  logic       set_brk;
  logic       set_hop;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (Clk_O),
    .rst_n (Reset),
    .btn   (Btn_Step),
    .pulse (step_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (Clk_O),
    .rst_n (Reset),
    .btn   (Btn_Run),
    .pulse (run_p)
  );

  // skip masks the breakpoint for the first enabled cycle after leaving HALT,
  // so a resume from a breakpoint executes the instruction it stopped on.
  assign is_halt_op = (Instruction == HALT_OPCODE);
  assign is_bkpt    = Bkpt_En & (PC == Bkpt_PC) & ~skip;
  assign CPU_En     = en;

  // Next-state and enable decode.
  always_comb begin
    next_state = state;
    en         = 1'b0;
    set_skip   = 1'b0;
    clr_flags  = 1'b0;
    set_brk    = 1'b0;
    set_hop    = 1'b0;
    unique case (state)
      ST_HALT: begin
        if (run_p) begin
          next_state = ST_RUN;
          set_skip   = 1'b1;
          clr_flags  = 1'b1;
        end else if (step_p) begin
          next_state = ST_STEP;
          set_skip   = 1'b1;
          clr_flags  = 1'b1;
        end
      end
      ST_STEP: begin
        en         = ~is_halt_op;
        set_hop    = is_halt_op;
        next_state = ST_HALT;
      end
      ST_RUN: begin
        if (is_halt_op || is_bkpt) begin
          // Halt opcode wins when both match on the same PC.
          next_state = ST_HALT;
          set_hop    = is_halt_op;
          set_brk    = ~is_halt_op;
        end else begin
          en = 1'b1;
          if (run_p) next_state = ST_HALT;
        end
      end
      default: next_state = ST_HALT;
    endcase
  end

  // State, flags and executed-instruction counter.
  always_ff @(posedge Clk_O or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_HALT;
      skip       <= 1'b0;
      Halted     <= 1'b1;
      Brk_Hit    <= 1'b0;
      Halt_Op    <= 1'b0;
      Step_Count <= '0;
    end else begin
      state  <= next_state;
      Halted <= (next_state == ST_HALT);
      if (set_skip)  skip <= 1'b1;
      else if (en)   skip <= 1'b0;
      if (clr_flags) begin
        Brk_Hit <= 1'b0;
        Halt_Op <= 1'b0;
      end else begin
        if (set_brk) Brk_Hit <= 1'b1;
        if (set_hop) Halt_Op <= 1'b1;
      end
      if (en && (Step_Count != {CNT_W{1'b1}})) Step_Count <= Step_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a tiny core model (PC advances by 4
// on each enabled edge, instruction read from a local IMEM) and a scoreboard
// of expected executed PCs consumed whenever CPU_En is observed high.
module tb_mips_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_step;
  logic       btn_run;
  logic       bkpt_en;
  logic [7:0] bkpt_pc;
  logic [7:0] pc;
  logic [7:0] instr;
  logic       cpu_en;
  logic       halted;
  logic       brk_hit;
  logic       halt_op;
  logic [3:0] step_count;

  logic [7:0] imem [256];
  int         exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  mips_run_ctrl #(.CNT_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .Clk_O       (clk),
    .Reset       (rst_n),
    .Btn_Step    (btn_step),
    .Btn_Run     (btn_run),
    .Bkpt_En     (bkpt_en),
    .Bkpt_PC     (bkpt_pc),
    .PC          (pc),
    .Instruction (instr),
    .CPU_En      (cpu_en),
    .Halted      (halted),
    .Brk_Hit     (brk_hit),
    .Halt_Op     (halt_op),
    .Step_Count  (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr = imem[pc];

  // Core model: advances only on enabled edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'd4;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard: every enabled cycle must execute the next expected PC.
  always @(negedge clk) begin
    if (rst_n && cpu_en) begin
      if (exp_q.size() == 0) check("exec_unexpected_pc", int'(pc), -1);
      else check("exec_pc", int'(pc), exp_q.pop_front());
    end
  end

  task automatic push_pcs(input int start, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back((start + 4 * i) & 8'hFF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called just after a negedge; raw level sampled at edge k=0 onward.
  task automatic press(input bit do_step, input bit do_run, input int hold, input int watch,
                       output int first_en, output int n_en);
    first_en = -1;
    n_en     = 0;
    btn_step = do_step;
    btn_run  = do_run;
    for (int k = 0; k < watch; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == hold - 1) begin
        btn_step = 1'b0;
        btn_run  = 1'b0;
      end
      if (cpu_en) begin
        n_en++;
        if (first_en < 0) first_en = k;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int first, n, bad;
    rst_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0; bkpt_en = 1'b0; bkpt_pc = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    // Reset and idle
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_halted", int'(halted), 1);
    check("rst_count", int'(step_count), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cpu_en || !halted) bad++;
    end
    check("idle_stable", bad, 0);

    // Single step, short press then long hold
    do_reset();
    push_pcs(0, 1);
    press(1'b1, 1'b0, 10, 20, first, n);
    check("step_latency", first, 7);
    check("step_pulses", n, 1);
    check("step_halted", int'(halted), 1);
    check("step_count", int'(step_count), 1);
    do_reset();
    push_pcs(0, 1);
    press(1'b1, 1'b0, 50, 60, first, n);
    check("hold_pulses", n, 1);
    check("hold_count", int'(step_count), 1);

    // Breakpoint stop and resume past it
    do_reset();
    bkpt_en = 1'b1; bkpt_pc = 8'h0C;
    imem[8'h20] = 8'hFF;
    push_pcs(0, 3);
    press(1'b0, 1'b1, 10, 20, first, n);
    check("bkpt_n_en", n, 3);
    check("bkpt_pc", int'(pc), 8'h0C);
    check("bkpt_cpu_en", int'(cpu_en), 0);
    check("bkpt_brk_hit", int'(brk_hit), 1);
    check("bkpt_halt_op", int'(halt_op), 0);
    check("bkpt_count", int'(step_count), 3);
    push_pcs(8'h0C, 5);
    press(1'b0, 1'b1, 10, 25, first, n);
    check("resume_n_en", n, 5);
    check("resume_pc", int'(pc), 8'h20);
    check("resume_brk_hit", int'(brk_hit), 0);
    check("resume_halt_op", int'(halt_op), 1);
    check("resume_count", int'(step_count), 8);
    imem[8'h20] = 8'h00;
    bkpt_en = 1'b0;

    // Halt opcode stop, then a step on it does nothing
    do_reset();
    imem[8'h10] = 8'hFF;
    push_pcs(0, 4);
    press(1'b0, 1'b1, 10, 20, first, n);
    check("hop_n_en", n, 4);
    check("hop_pc", int'(pc), 8'h10);
    check("hop_halt_op", int'(halt_op), 1);
    check("hop_brk_hit", int'(brk_hit), 0);
    check("hop_count", int'(step_count), 4);
    press(1'b1, 1'b0, 10, 20, first, n);
    check("hop_step_n_en", n, 0);
    check("hop_step_count", int'(step_count), 4);
    check("hop_step_halt_op", int'(halt_op), 1);
    check("hop_step_halted", int'(halted), 1);

    // Halt opcode and breakpoint on the same PC
    do_reset();
    bkpt_en = 1'b1; bkpt_pc = 8'h10;
    push_pcs(0, 4);
    press(1'b0, 1'b1, 10, 20, first, n);
    check("both_halt_op", int'(halt_op), 1);
    check("both_brk_hit", int'(brk_hit), 0);
    check("both_pc", int'(pc), 8'h10);
    imem[8'h10] = 8'h00;
    bkpt_en = 1'b0;

    // Simultaneous press enters RUN; later Run press pauses; count saturates
    do_reset();
    push_pcs(0, 20);
    press(1'b1, 1'b1, 10, 20, first, n);
    check("sim_first_en", first, 7);
    check("sim_n_en", n, 13);
    check("sim_running", int'(halted), 0);
    press(1'b0, 1'b1, 10, 15, first, n);
    check("pause_n_en", n, 7);
    check("pause_halted", int'(halted), 1);
    check("pause_pc", int'(pc), 8'h50);
    check("sat_count", int'(step_count), 15);

    // Async reset in the middle of RUN
    do_reset();
    push_pcs(0, 5);
    press(1'b0, 1'b1, 10, 12, first, n);
    check("mid_run_en", int'(cpu_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_cpu_en", int'(cpu_en), 0);
    check("async_halted", int'(halted), 1);
    check("async_count", int'(step_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Run-control sequencer for the MIPS core. Produces the core's clock-enable so the core can free-run, single-step or halt.
- Takes two raw push-buttons (Step, Run), a PC breakpoint and a halt opcode. Provides a saturating executed-instruction counter for the seven-segment display path.
- Sits between the board buttons and the MIPS core. Observes the PC and Instruction buses shared with IMEM.

Parameters:
- PC_W, 8, width of PC and Bkpt_PC.
- INSTR_W, 8, width of Instruction.
- CNT_W, 8, width of Step_Count.
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a button level (synthesis builds override this to about 2^18).
- HALT_OPCODE, 8'hFF, instruction value that stops execution.

Ports:
- Clk_O  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- Btn_Step  input  1  raw step button, active-high, asynchronous to Clk_O.
- Btn_Run  input  1  raw run/pause toggle button, active-high, asynchronous.
- Bkpt_En  input  1  breakpoint enable.
- Bkpt_PC  input  PC_W  breakpoint address.
- PC  input  PC_W  current core PC.
- Instruction  input  INSTR_W  current fetched instruction (from IMEM).
- CPU_En  output  1  core advances on a rising edge only while CPU_En=1; combinational from state and inputs.
- Halted  output  1  registered; 1 in HALT state.
- Brk_Hit  output  1  registered sticky flag; set on breakpoint stop, cleared on the next run or step start.
- Halt_Op  output  1  registered sticky flag; set on HALT_OPCODE stop, cleared on the next run or step start.
- Step_Count  output  CNT_W  registered count of enabled cycles, saturating.

Behaviour:
- Reset (async, Reset=0):
  - State=HALT.
  - Halted=1; Brk_Hit, Halt_Op and Step_Count=0.
  - Sync and debounce registers are cleared.
  - CPU_En=0 while Reset=0.
  - Reset mid-RUN takes effect immediately, with no completing cycle.
- Button conditioning, each button independently:
  - 2-flop synchronizer, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A rising edge of the accepted level gives a 1-cycle pulse (step_p, run_p). Holding the button gives one pulse only.
  - Latency: first raw-high sample edge to pulse is 2+DEBOUNCE_CYCLES cycles.
- Stop condition: stop = (Instruction==HALT_OPCODE) OR (Bkpt_En AND PC==Bkpt_PC AND NOT skip).
  - skip is set when leaving HALT and cleared after the first enabled cycle. This lets the core resume past a breakpoint it stopped on.
- States: HALT, STEP, RUN.
  - HALT, run_p: go to RUN and set skip. Brk_Hit and Halt_Op are cleared. run_p takes priority over a simultaneous step_p.
  - HALT, step_p: go to STEP and set skip; flags are cleared.
  - STEP: one cycle only. CPU_En = NOT (Instruction==HALT_OPCODE); the breakpoint is ignored because skip=1. Then go to HALT. If HALT_OPCODE is present, set Halt_Op.
  - RUN: CPU_En = NOT stop.
    - If stop: go to HALT and set Brk_Hit or Halt_Op. Halt_Op takes priority when both match.
    - If run_p: go to HALT, with CPU_En still 1 in that cycle.
    - step_p is ignored.
- Stopping rule: the core stops before executing the stopping instruction; PC holds the matching address.
- Step_Count increments by 1 on every edge where CPU_En=1 and holds at 2^CNT_W-1.
- Halted equals (next state==HALT), registered, so it rises the cycle after the stop.

Decomposition:
- Shared package mips_ctrl_pkg: state encoding (HALT=2'd0, STEP=2'd1, RUN=2'd2), HALT_OPCODE default, width constants.
- One sub-module, btn_debounce (synchronizer, debounce counter, rising-edge pulse), instantiated twice.

Test Plan:
- Reset/idle: hold Reset=0 for 5 cycles, then release -> Halted=1, CPU_En=0, Step_Count=0. With no button activity, the state stays HALT for 100 cycles.
- Single step: pulse Btn_Step high 10 cycles with DEBOUNCE_CYCLES=4 -> CPU_En=1 for exactly one cycle, 7 cycles after the first high sample, then Halted=1 and Step_Count=1. Holding the button 50 cycles still gives one step.
- Breakpoint: Bkpt_En=1, Bkpt_PC=8'h0C, run from PC=0 with PC advancing by 4 -> CPU_En=0 when PC==0x0C, Brk_Hit=1, Step_Count=3. A second Run press executes 0x0C and continues with no re-stop.
- Halt opcode: IMEM holds 8'hFF at PC 0x10, Run pressed -> stop with PC=0x10, Halt_Op=1, Step_Count=4. A Step press gives no CPU_En pulse and Step_Count stays 4.
- Simultaneous and pause: Step and Run pressed on the same cycle in HALT -> RUN entered. A later Run press in RUN -> one final enabled cycle, then HALT.
- Async reset mid-run: Reset=0 between clock edges while in RUN -> CPU_En=0 and Halted=1 immediately, without waiting for an edge. Step_Count=0; with CNT_W=4 and a long run, the count saturates at 15.
